// File: rtl/nibble_add_seq_pkg.sv
// Shared constants for the nibble-serial adder.
//   NIBBLE_W : width of one nibble processed per cycle
//   state_t  : controller states IDLE / RUN / DONE
package nibble_add_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_seq_adder4.sv
// adder4 -- 4-bit nibble adder with carry in.
// Ports:
//   a, b     : nibble operands
//   cin      : carry in
//   sum      : 4-bit sum
//   overflow : carry out of bit 3
//   zero     : sum == 0
module adder4
    import nibble_add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                overflow,
    output logic                zero
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign zero            = (sum == '0);

endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq -- W-bit unsigned adder that processes one nibble per clock.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : begin an addition (honoured in IDLE or DONE only)
//   a, b     : W-bit operands, latched on the accepting edge
//   cin      : carry into nibble 0, latched on the accepting edge
//   busy     : high while nibbles are being processed
//   done     : one-cycle pulse marking a valid result
//   y        : sum (valid from done until the next accepting edge)
//   overflow : unsigned carry out of bit W-1
//   zero     : y == 0 for the completed result
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  y,
    output logic                         overflow,
    output logic                         zero
);

    localparam int unsigned W    = NIBBLE_W * NIBBLES;
    localparam int unsigned CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_step;
    logic                w_last;

    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic                r_carry;
    logic [CW-1:0]       r_cnt;
    logic [W-1:0]        r_y;
    logic                r_overflow;
    logic                r_zero;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
    logic                w_unused_nib_zero;
    logic [W-1:0]        w_y_next;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- nibble datapath ----------------
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_cnt == i[CW-1:0]) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    adder4 u_adder4 (
        .a        (w_a_nib),
        .b        (w_b_nib),
        .cin      (r_carry),
        .sum      (w_nib_sum),
        .overflow (w_nib_cout),
        .zero     (w_unused_nib_zero)
    );

    // Result with the current nibble merged in; lets the zero flag see the
    // final nibble in the same cycle it is written.
    always_comb begin
        w_y_next = r_y;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_cnt == i[CW-1:0]) begin
                w_y_next[i*NIBBLE_W +: NIBBLE_W] = w_nib_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_y        <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_y     <= w_y_next;
            r_carry <= w_nib_cout;
            if (w_last) begin
                r_cnt      <= '0;
                r_overflow <= w_nib_cout;
                r_zero     <= (w_y_next == '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign y        = r_y;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
